// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: write-back source
// codes, default widths and the in-flight counter ceiling.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    localparam logic [2:0] WB_ALU  = 3'd0;
    localparam logic [2:0] WB_EXT  = 3'd1;
    localparam logic [2:0] WB_DRAM = 3'd2;
    localparam logic [2:0] WB_PC4  = 3'd3;

    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// Decode/write-back bundle of the scoreboarded register file.
// Handshake: decode offers an instruction with iss_valid; it is accepted on a
// rising edge where iss_valid=1 and stall=0, otherwise decode holds all iss_*
// and rd_* inputs unchanged. Write-back has no back-pressure.
interface rf_scoreboard_if
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_READ = 2
);

    logic [NUM_READ*ADDR_W-1:0] rd_addr;
    logic [NUM_READ-1:0]        rd_used;
    logic [NUM_READ*DATA_W-1:0] rd_data;
    logic                       iss_valid;
    logic                       iss_wen;
    logic [ADDR_W-1:0]          iss_dest;
    logic                       stall;
    logic                       wb_we;
    logic [ADDR_W-1:0]          wb_addr;
    logic [2:0]                 wb_sel;
    logic [DATA_W-1:0]          wb_alu;
    logic [DATA_W-1:0]          wb_sext;
    logic [DATA_W-1:0]          wb_dram;
    logic [DATA_W-1:0]          wb_pc4;
    logic [DATA_W-1:0]          wb_value;
    logic                       sb_err;

    modport master (
        output rd_addr, rd_used, iss_valid, iss_wen, iss_dest,
               wb_we, wb_addr, wb_sel, wb_alu, wb_sext, wb_dram, wb_pc4,
        input  rd_data, stall, wb_value, sb_err
    );

    modport slave (
        input  rd_addr, rd_used, iss_valid, iss_wen, iss_dest,
               wb_we, wb_addr, wb_sel, wb_alu, wb_sext, wb_dram, wb_pc4,
        output rd_data, stall, wb_value, sb_err
    );

endinterface

// File: rtl/rf_wb_mux.sv
// Four-source write-back data selector; unknown select codes fall back to ALU.
module rf_wb_mux
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W
) (
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] sext,
    input  logic [DATA_W-1:0] dram,
    input  logic [DATA_W-1:0] pc4,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        case (sel)
            WB_EXT:  y = sext;
            WB_DRAM: y = dram;
            WB_PC4:  y = pc4;
            default: y = alu;
        endcase
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Multi-port register file with per-register pending-write counters that raise
// the decode stall on RAW hazards. Define RF_BYPASS_EN for same-cycle forwarding.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_READ = 2,
    parameter int CNT_W    = 2
) (
    input logic          clk,
    input logic          rst_n,
    rf_scoreboard_if.slave bus
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  cnt  [NREG];
    logic              sb_err_q;
    logic [DATA_W-1:0] wb_val;
    logic              wb_dec;
    logic              inc;
    logic              full;
    logic [NUM_READ-1:0] port_haz;
    logic [DATA_W-1:0]   rdata [NUM_READ];

    rf_wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .sel  (bus.wb_sel),
        .alu  (bus.wb_alu),
        .sext (bus.wb_sext),
        .dram (bus.wb_dram),
        .pc4  (bus.wb_pc4),
        .y    (wb_val)
    );

    assign wb_dec = bus.wb_we && (bus.wb_addr != '0);

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        logic [ADDR_W-1:0] a;
        logic              resolved;
        assign a = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
        logic fwd;
        assign fwd      = wb_dec && (bus.wb_addr == a);
        assign rdata[i] = fwd ? wb_val : regs[a];
        // The in-flight write lands this very cycle, so the last pending count is satisfied.
        assign resolved = fwd && (cnt[a] == CNT_W'(1));
`else
        assign rdata[i] = regs[a];
        assign resolved = 1'b0;
`endif
        assign port_haz[i] = bus.rd_used[i] && (a != '0) && (cnt[a] != '0) && !resolved;
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = rdata[i];
        end
    end

    // A full counter is tolerable when a write-back retires one of its entries now.
    assign full = bus.iss_wen && (bus.iss_dest != '0) && (cnt[bus.iss_dest] == CMAX)
                  && !(wb_dec && (bus.wb_addr == bus.iss_dest));

    assign bus.stall    = bus.iss_valid && ((|port_haz) || full);
    assign inc          = bus.iss_valid && bus.iss_wen && !bus.stall && (bus.iss_dest != '0);
    assign bus.wb_value = wb_val;
    assign bus.sb_err   = sb_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (wb_dec) begin
                regs[bus.wb_addr] <= wb_val;
                if (cnt[bus.wb_addr] == '0) sb_err_q <= 1'b1;
            end
            for (int r = 1; r < NREG; r++) begin
                if (inc && (bus.iss_dest == ADDR_W'(r)) && !(wb_dec && (bus.wb_addr == ADDR_W'(r)))) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (wb_dec && (bus.wb_addr == ADDR_W'(r)) && !(inc && (bus.iss_dest == ADDR_W'(r)))
                             && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard (NUM_READ=2, CNT_W=2); honours RF_BYPASS_EN.
module tb_rf_scoreboard;
  import rf_pkg::*;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   chk_cnt;
  logic [31:0] exp_q[$];
  logic [31:0] ref_regs [32];
  logic        pend_we;
  logic [4:0]  pend_addr;
  logic [31:0] pend_val;

  rf_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) bus ();

  rf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.rd_addr   = '0;
    bus.rd_used   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_wen   = 1'b0;
    bus.iss_dest  = '0;
    bus.wb_we     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_sel    = WB_ALU;
    bus.wb_alu    = $urandom;
    bus.wb_sext   = $urandom;
    bus.wb_dram   = $urandom;
    bus.wb_pc4    = $urandom;
  endtask

  task automatic set_rd(input int port, input logic [4:0] a, input logic used);
    bus.rd_addr[port*5 +: 5] = a;
    bus.rd_used[port]        = used;
  endtask

  task automatic issue(input logic wen, input logic [4:0] dest);
    bus.iss_valid = 1'b1;
    bus.iss_wen   = wen;
    bus.iss_dest  = dest;
  endtask

  // Drives a write-back whose selected source carries data; others get noise.
  task automatic wb_drive(input logic [4:0] addr, input logic [2:0] sel, input logic [31:0] data);
    bus.wb_we   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_sel  = sel;
    bus.wb_alu  = $urandom;
    bus.wb_sext = $urandom;
    bus.wb_dram = $urandom;
    bus.wb_pc4  = $urandom;
    case (sel)
      WB_EXT:  bus.wb_sext = data;
      WB_DRAM: bus.wb_dram = data;
      WB_PC4:  bus.wb_pc4  = data;
      default: bus.wb_alu  = data;
    endcase
    pend_we   = 1'b1;
    pend_addr = addr;
    pend_val  = data;
  endtask

  // Advance one cycle; the bench model commits the pending write at the edge.
  task automatic step();
    if (pend_we && pend_addr != 5'd0) ref_regs[pend_addr] = pend_val;
    pend_we = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] e;
    rst_n = 1'b0;
    idle();
    set_rd(0, 5'd5, 1'b1);
    set_rd(1, 5'd0, 1'b1);
    issue(1'b1, 5'd5);
    bus.wb_sel = WB_PC4;
    bus.wb_pc4 = 32'h0000_1234;
    @(negedge clk);
    #1;
    chk_cnt++;
    if (bus.rd_data !== 64'd0) $display("FAIL rst_rd_data: got %h, required 0", bus.rd_data);
    else pass_cnt++;
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL rst_stall: got %b, required 0", bus.stall);
    else pass_cnt++;
    chk_cnt++;
    if (bus.wb_value !== 32'h0000_1234) $display("FAIL rst_wb_value: got %h, required 00001234", bus.wb_value);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    set_rd(0, 5'd5, 1'b0);
    set_rd(1, 5'd0, 1'b0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front();
    chk_cnt++;
    if (bus.rd_data[31:0] !== e) $display("FAIL reset_read_x5: got %h, required %h", bus.rd_data[31:0], e);
    else pass_cnt++;
    e = exp_q.pop_front();
    chk_cnt++;
    if (bus.rd_data[63:32] !== e) $display("FAIL reset_read_x0: got %h, required %h", bus.rd_data[63:32], e);
    else pass_cnt++;
    chk_cnt++;
    if (bus.sb_err !== 1'b0) $display("FAIL reset_sb_err: got %b, required 0", bus.sb_err);
    else pass_cnt++;
    step();
  endtask

  task automatic test_mux();
    logic [31:0] e;
    for (int s = 0; s < 8; s++) begin
      idle();
      bus.wb_sel = 3'(s);
      case (s)
        1:       e = bus.wb_sext;
        2:       e = bus.wb_dram;
        3:       e = bus.wb_pc4;
        default: e = bus.wb_alu;
      endcase
      #1;
      chk_cnt++;
      if (bus.wb_value !== e) $display("FAIL mux_sel%0d: got %h, required %h", s, bus.wb_value, e);
      else pass_cnt++;
    end
    step();
  endtask

  task automatic test_write_readback();
    logic [31:0] e;
    logic [31:0] d;
    logic [2:0]  sel;
    idle();
    issue(1'b1, 5'd7);
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL wr_issue_stall: got %b, required 0", bus.stall);
    else pass_cnt++;
    step();
    idle();
    wb_drive(5'd7, WB_EXT, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    chk_cnt++;
    if (bus.wb_value !== 32'hDEAD_BEEF) $display("FAIL wr_wb_value: got %h, required deadbeef", bus.wb_value);
    else pass_cnt++;
    step();
    idle();
    wb_drive(5'd0, WB_ALU, 32'h0BAD_0BAD);
    exp_q.push_back(32'd0);
    step();
    idle();
    set_rd(0, 5'd7, 1'b0);
    set_rd(1, 5'd0, 1'b0);
    #1;
    e = exp_q.pop_front();
    chk_cnt++;
    if (bus.rd_data[31:0] !== e) $display("FAIL readback_x7: got %h, required %h", bus.rd_data[31:0], e);
    else pass_cnt++;
    e = exp_q.pop_front();
    chk_cnt++;
    if (bus.rd_data[63:32] !== e) $display("FAIL readback_x0: got %h, required %h", bus.rd_data[63:32], e);
    else pass_cnt++;
    chk_cnt++;
    if (bus.sb_err !== 1'b0) $display("FAIL wr_sb_err: got %b, required 0", bus.sb_err);
    else pass_cnt++;
    step();
    // Random sources and data into x13..x16, each preceded by its issue.
    for (int k = 0; k < 4; k++) begin
      idle();
      issue(1'b1, 5'(13 + k));
      step();
      idle();
      sel = 3'($urandom_range(0, 3));
      d   = $urandom;
      wb_drive(5'(13 + k), sel, d);
      exp_q.push_back(d);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      idle();
      set_rd(0, 5'(13 + 2*k), 1'b0);
      set_rd(1, 5'(14 + 2*k), 1'b0);
      #1;
      e = exp_q.pop_front();
      chk_cnt++;
      if (bus.rd_data[31:0] !== e) $display("FAIL rand_rd_x%0d: got %h, required %h", 13 + 2*k, bus.rd_data[31:0], e);
      else pass_cnt++;
      e = exp_q.pop_front();
      chk_cnt++;
      if (bus.rd_data[63:32] !== e) $display("FAIL rand_rd_x%0d: got %h, required %h", 14 + 2*k, bus.rd_data[63:32], e);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_raw_stall();
    logic [31:0] e;
    logic        es;
    idle();
    issue(1'b1, 5'd3);
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL raw_producer_stall: got %b, required 0", bus.stall);
    else pass_cnt++;
    step();
    for (int c = 0; c < 2; c++) begin
      idle();
      issue(1'b0, 5'd0);
      set_rd(1, 5'd3, 1'b1);
      #1;
      chk_cnt++;
      if (bus.stall !== 1'b1) $display("FAIL raw_wait%0d_stall: got %b, required 1", c, bus.stall);
      else pass_cnt++;
      step();
    end
    idle();
    issue(1'b0, 5'd0);
    set_rd(1, 5'd3, 1'b1);
    wb_drive(5'd3, WB_ALU, 32'hA5A5_0003);
    es = BYP ? 1'b0 : 1'b1;
    exp_q.push_back(BYP ? 32'hA5A5_0003 : ref_regs[3]);
    #1;
    chk_cnt++;
    if (bus.stall !== es) $display("FAIL raw_wb_cycle_stall: got %b, required %b", bus.stall, es);
    else pass_cnt++;
    e = exp_q.pop_front();
    chk_cnt++;
    if (bus.rd_data[63:32] !== e) $display("FAIL raw_wb_cycle_data: got %h, required %h", bus.rd_data[63:32], e);
    else pass_cnt++;
    step();
    idle();
    issue(1'b0, 5'd0);
    set_rd(1, 5'd3, 1'b1);
    exp_q.push_back(ref_regs[3]);
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL raw_after_wb_stall: got %b, required 0", bus.stall);
    else pass_cnt++;
    e = exp_q.pop_front();
    chk_cnt++;
    if (bus.rd_data[63:32] !== e) $display("FAIL raw_after_wb_data: got %h, required %h", bus.rd_data[63:32], e);
    else pass_cnt++;
    step();
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 3; c++) begin
      idle();
      issue(1'b1, 5'd9);
      #1;
      chk_cnt++;
      if (bus.stall !== 1'b0) $display("FAIL sat_issue%0d_stall: got %b, required 0", c, bus.stall);
      else pass_cnt++;
      step();
    end
    for (int c = 0; c < 2; c++) begin
      idle();
      issue(1'b1, 5'd9);
      #1;
      chk_cnt++;
      if (bus.stall !== 1'b1) $display("FAIL sat_full%0d_stall: got %b, required 1", c, bus.stall);
      else pass_cnt++;
      step();
    end
    idle();
    issue(1'b1, 5'd9);
    wb_drive(5'd9, WB_DRAM, $urandom);
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL sat_wb_release_stall: got %b, required 0", bus.stall);
    else pass_cnt++;
    step();
    idle();
    issue(1'b1, 5'd9);
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b1) $display("FAIL sat_still_full_stall: got %b, required 1", bus.stall);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      idle();
      wb_drive(5'd9, WB_ALU, $urandom);
      step();
      if (c == 1) begin
        idle();
        issue(1'b0, 5'd0);
        set_rd(0, 5'd9, 1'b1);
        #1;
        chk_cnt++;
        if (bus.stall !== 1'b1) $display("FAIL sat_one_left_stall: got %b, required 1", bus.stall);
        else pass_cnt++;
        step();
      end
    end
    idle();
    issue(1'b0, 5'd0);
    set_rd(0, 5'd9, 1'b1);
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL sat_drained_stall: got %b, required 0", bus.stall);
    else pass_cnt++;
    chk_cnt++;
    if (bus.sb_err !== 1'b0) $display("FAIL sat_sb_err: got %b, required 0", bus.sb_err);
    else pass_cnt++;
    step();
  endtask

  task automatic test_inc_dec();
    logic [31:0] e;
    logic        es;
    idle();
    issue(1'b1, 5'd4);
    step();
    idle();
    issue(1'b1, 5'd4);
    wb_drive(5'd4, WB_DRAM, 32'h4444_4444);
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL incdec_same_cycle_stall: got %b, required 0", bus.stall);
    else pass_cnt++;
    step();
    idle();
    issue(1'b0, 5'd0);
    set_rd(0, 5'd4, 1'b1);
    exp_q.push_back(ref_regs[4]);
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b1) $display("FAIL incdec_cnt1_stall: got %b, required 1", bus.stall);
    else pass_cnt++;
    e = exp_q.pop_front();
    chk_cnt++;
    if (bus.rd_data[31:0] !== e) $display("FAIL incdec_data: got %h, required %h", bus.rd_data[31:0], e);
    else pass_cnt++;
    step();
    idle();
    issue(1'b0, 5'd0);
    set_rd(0, 5'd4, 1'b1);
    wb_drive(5'd4, WB_PC4, 32'h5555_5555);
    es = BYP ? 1'b0 : 1'b1;
    exp_q.push_back(BYP ? 32'h5555_5555 : ref_regs[4]);
    #1;
    chk_cnt++;
    if (bus.stall !== es) $display("FAIL incdec_final_wb_stall: got %b, required %b", bus.stall, es);
    else pass_cnt++;
    e = exp_q.pop_front();
    chk_cnt++;
    if (bus.rd_data[31:0] !== e) $display("FAIL incdec_final_wb_data: got %h, required %h", bus.rd_data[31:0], e);
    else pass_cnt++;
    step();
    idle();
    issue(1'b0, 5'd0);
    set_rd(0, 5'd4, 1'b1);
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL incdec_drained_stall: got %b, required 0", bus.stall);
    else pass_cnt++;
    chk_cnt++;
    if (bus.sb_err !== 1'b0) $display("FAIL incdec_sb_err: got %b, required 0", bus.sb_err);
    else pass_cnt++;
    step();
  endtask

  task automatic test_underflow();
    logic [31:0] e;
    idle();
    wb_drive(5'd12, WB_EXT, 32'h1212_1212);
    exp_q.push_back(32'h1212_1212);
    step();
    idle();
    set_rd(0, 5'd12, 1'b0);
    #1;
    chk_cnt++;
    if (bus.sb_err !== 1'b1) $display("FAIL underflow_sb_err: got %b, required 1", bus.sb_err);
    else pass_cnt++;
    e = exp_q.pop_front();
    chk_cnt++;
    if (bus.rd_data[31:0] !== e) $display("FAIL underflow_write: got %h, required %h", bus.rd_data[31:0], e);
    else pass_cnt++;
    step();
    idle();
    step();
    idle();
    step();
    #1;
    chk_cnt++;
    if (bus.sb_err !== 1'b1) $display("FAIL underflow_sticky: got %b, required 1", bus.sb_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    idle();
    issue(1'b1, 5'd25);
    step();
    idle();
    issue(1'b1, 5'd26);
    step();
    idle();
    issue(1'b0, 5'd0);
    set_rd(0, 5'd25, 1'b1);
    set_rd(1, 5'd26, 1'b1);
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b1) $display("FAIL midrst_pre_stall: got %b, required 1", bus.stall);
    else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL midrst_stall: got %b, required 0", bus.stall);
    else pass_cnt++;
    chk_cnt++;
    if (bus.sb_err !== 1'b0) $display("FAIL midrst_sb_err: got %b, required 0", bus.sb_err);
    else pass_cnt++;
    set_rd(0, 5'd7, 1'b1);
    #1;
    chk_cnt++;
    if (bus.rd_data[31:0] !== 32'd0) $display("FAIL midrst_x7_cleared: got %h, required 0", bus.rd_data[31:0]);
    else pass_cnt++;
    for (int r = 0; r < 32; r++) ref_regs[r] = '0;
    step();
    rst_n = 1'b1;
    set_rd(0, 5'd25, 1'b1);
    #1;
    chk_cnt++;
    if (bus.stall !== 1'b0) $display("FAIL midrst_after_release_stall: got %b, required 0", bus.stall);
    else pass_cnt++;
    step();
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    pend_we  = 1'b0;
    pend_addr = '0;
    pend_val = '0;
    for (int r = 0; r < 32; r++) ref_regs[r] = '0;
    test_reset();
    test_mux();
    test_write_readback();
    test_raw_stall();
    test_saturation();
    test_inc_dec();
    test_underflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
